golomb_dec: RTL and testbench

Bit-serial Golomb-Rice token decoder for the JPEG-LS regular-mode decode path. It is the inverse of the encoder's final stages, which emit unary prefix, remainder bits and the escape code. The block pulls entropy-coded bytes MSB-first, removes 0xFF bit-stuffing, and decodes one mapped error value (merrval) per request using the k supplied by the decoder's context model. It sits between the scan byte source and the decoder's context/reconstruction pipeline.

---
 rtl/golomb_dec.sv | 137 +++++++++++++
 tb/tb_golomb_dec.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/golomb_dec.sv
// Bit-serial Golomb-Rice token decoder for the JPEG-LS regular-mode path.
// Pulls stuffed bytes MSB-first and decodes one merrval per request.
module golomb_dec #(
    parameter int LIMIT = 23,
    parameter int QBPP  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_byte_vl,
    input  logic [7:0] i_byte,
    output logic       o_byte_rdy,
    input  logic       i_req_vl,
    input  logic [3:0] i_k,
    output logic       o_req_rdy,
    output logic       o_vl,
    output logic [8:0] o_merr,
    output logic       o_err
);
    localparam int QW = $clog2(LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ZERO, BITS, ERR} state_t;

    state_t        state, state_n;
    logic [7:0]    cur;
    logic [3:0]    nb;
    logic          ff;
    logic [QW-1:0] q, q_n;
    logic [10:0]   r, r_n;
    logic [3:0]    cnt, cnt_n;
    logic [3:0]    k, k_n;
    logic [3:0]    n;
    logic          consume, emit, err_set;
    logic          byte_acc, marker, bit_in, escape;
    logic [15:0]   wide;
    logic [8:0]    merr_n;

    assign o_byte_rdy = (nb == 4'd0) && !o_err;
    assign o_req_rdy  = (state == IDLE);
    assign byte_acc   = i_byte_vl && o_byte_rdy;
    assign marker     = byte_acc && ff && i_byte[7];
    assign bit_in     = cur[7];
    assign escape     = (q == QW'(LIMIT));
    assign n          = escape ? 4'(QBPP) : k;

    // Value is formed from the remainder including the bit consumed this cycle.
    assign wide   = (16'(q) << k) | 16'(r_n);
    assign merr_n = escape ? ({1'b0, r_n[7:0]} + 9'd1) : wide[8:0];

    always_comb begin
        state_n = state;
        q_n     = q;
        r_n     = r;
        cnt_n   = cnt;
        k_n     = k;
        consume = 1'b0;
        emit    = 1'b0;
        err_set = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_req_vl) begin
                    k_n     = i_k;
                    q_n     = '0;
                    r_n     = '0;
                    state_n = ZERO;
                end
            end
            ZERO: begin
                if (nb != 4'd0) begin
                    consume = 1'b1;
                    if (!bit_in) begin
                        if (escape) begin
                            err_set = 1'b1;
                            state_n = ERR;
                        end else begin
                            q_n = q + 1'b1;
                        end
                    end else if (n == 4'd0) begin
                        emit = 1'b1;
                    end else begin
                        cnt_n   = n;
                        state_n = BITS;
                    end
                end
            end
            BITS: begin
                if (nb != 4'd0) begin
                    consume = 1'b1;
                    r_n     = {r[9:0], bit_in};
                    cnt_n   = cnt - 4'd1;
                    if (cnt == 4'd1) emit = 1'b1;
                end
            end
            ERR: begin
            end
        endcase
        if (emit) state_n = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            nb     <= '0;
            ff     <= 1'b0;
            q      <= '0;
            r      <= '0;
            cnt    <= '0;
            k      <= '0;
            o_vl   <= 1'b0;
            o_merr <= '0;
            o_err  <= 1'b0;
        end else begin
            state <= marker ? ERR : state_n;
            q     <= q_n;
            r     <= r_n;
            cnt   <= cnt_n;
            k     <= k_n;
            o_vl  <= emit;
            if (emit) o_merr <= merr_n;
            if (err_set || marker) o_err <= 1'b1;
            // Loads only happen with nb==0, so they never collide with a consume.
            if (byte_acc) begin
                ff <= (i_byte == 8'hFF);
                if (ff) begin
                    cur <= {i_byte[6:0], 1'b0};
                    nb  <= 4'd7;
                end else begin
                    cur <= i_byte;
                    nb  <= 4'd8;
                end
            end else if (consume) begin
                cur <= {cur[6:0], 1'b0};
                nb  <= nb - 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_golomb_dec.sv
// Directed self-checking bench for golomb_dec.
// Bytes are fed from a queue; tokens are checked against hand-computed values.
module tb_golomb_dec;
    logic       clk;
    logic       rst;
    logic       i_byte_vl;
    logic [7:0] i_byte;
    logic       o_byte_rdy;
    logic       i_req_vl;
    logic [3:0] i_k;
    logic       o_req_rdy;
    logic       o_vl;
    logic [8:0] o_merr;
    logic       o_err;

    golomb_dec dut (
        .clk        (clk),
        .rst        (rst),
        .i_byte_vl  (i_byte_vl),
        .i_byte     (i_byte),
        .o_byte_rdy (o_byte_rdy),
        .i_req_vl   (i_req_vl),
        .i_k        (i_k),
        .o_req_rdy  (o_req_rdy),
        .o_vl       (o_vl),
        .o_merr     (o_merr),
        .o_err      (o_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    logic [7:0] bq[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Byte source: presents the queue head whenever the decoder is ready.
    initial begin
        i_byte_vl = 1'b0;
        i_byte    = 8'h00;
        forever begin
            @(negedge clk);
            if (i_byte_vl && bq.size() > 0) void'(bq.pop_front());
            if (!rst && o_byte_rdy && bq.size() > 0) begin
                i_byte_vl = 1'b1;
                i_byte    = bq[0];
            end else begin
                i_byte_vl = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        bq.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_load();
        for (int i = 0; i < 20; i++) begin
            if (!o_byte_rdy) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_req(input logic [3:0] k);
        int w;
        w = 0;
        @(negedge clk);
        while (!o_req_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        i_req_vl = 1'b1;
        i_k      = k;
        @(posedge clk);
        #1 i_req_vl = 1'b0;
    endtask

    task automatic req(input logic [3:0] k, output int cyc,
                       output logic [8:0] m);
        start_req(k);
        cyc = 0;
        m   = 'x;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (o_vl) begin
                m = o_merr;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int vl;
        int bad;
        logic [8:0] m;

        rst      = 1'b1;
        i_req_vl = 1'b0;
        i_k      = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_vl", 16'(o_vl), 16'd0);
        check("rst_merr", 16'(o_merr), 16'd0);
        check("rst_err", 16'(o_err), 16'd0);
        check("rst_byte_rdy", 16'(o_byte_rdy), 16'd1);
        check("rst_req_rdy", 16'(o_req_rdy), 16'd1);

        // 0x30 = 00 1 10 ..., k=2 -> q=2 r=2 -> 10
        bq.push_back(8'h30);
        wait_load();
        check("basic_loaded", 16'(o_byte_rdy), 16'd0);
        req(4'd2, cyc, m);
        check("basic_merr", 16'(m), 16'd10);
        check("basic_lat", 16'(cyc), 16'd5);
        check("basic_req_rdy", 16'(o_req_rdy), 16'd1);
        @(posedge clk);
        #1;
        check("basic_vl_pulse", 16'(o_vl), 16'd0);
        check("basic_left", 16'(o_byte_rdy), 16'd0);

        // Leftover 000 plus 0x80 -> q=3; one refill stall
        bq.push_back(8'h80);
        req(4'd0, cyc, m);
        check("left_merr", 16'(m), 16'd3);
        check("left_lat", 16'(cyc), 16'd5);

        // 23 zeros then escape, remainder 0x7F -> 128
        do_reset();
        bq.push_back(8'h00);
        bq.push_back(8'h00);
        bq.push_back(8'h01);
        bq.push_back(8'h7F);
        req(4'd5, cyc, m);
        check("esc_merr", 16'(m), 16'd128);
        check("esc_empty", 16'(o_byte_rdy), 16'd1);
        check("esc_err", 16'(o_err), 16'd0);

        // 0xFF then stuffed 0x7F: 8 + 7 one-bit tokens
        do_reset();
        bq.push_back(8'hFF);
        bq.push_back(8'h7F);
        for (int i = 0; i < 15; i++) begin
            req(4'd0, cyc, m);
            check("stuff_tok", 16'(m), 16'd0);
        end
        check("stuff_empty", 16'(o_byte_rdy), 16'd1);
        bq.push_back(8'hFF);
        bq.push_back(8'h80);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            req(4'd0, cyc, m);
            if (m !== 9'd0) bad++;
        end
        check("stuff_ff_toks", 16'(bad), 16'd0);
        for (int i = 0; i < 5; i++) begin
            if (o_err) break;
            @(posedge clk);
            #1;
        end
        check("marker_err", 16'(o_err), 16'd1);
        check("marker_byte_rdy", 16'(o_byte_rdy), 16'd0);
        check("marker_req_rdy", 16'(o_req_rdy), 16'd0);

        // 24 zeros -> error, absorbing
        do_reset();
        repeat (4) bq.push_back(8'h00);
        start_req(4'd0);
        vl = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (o_vl) vl++;
        end
        check("long_err", 16'(o_err), 16'd1);
        check("long_no_vl", 16'(vl), 16'd0);
        check("long_req_rdy", 16'(o_req_rdy), 16'd0);
        check("long_byte_rdy", 16'(o_byte_rdy), 16'd0);

        // Reset two bits into a token that follows a stuffed byte
        do_reset();
        bq.push_back(8'hFF);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            req(4'd0, cyc, m);
            if (m !== 9'd0) bad++;
        end
        check("mid_ff_toks", 16'(bad), 16'd0);
        bq.push_back(8'h00);
        wait_load();
        start_req(4'd3);
        vl = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (o_vl) vl++;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (o_vl) vl++;
        end
        check("mid_no_vl", 16'(vl), 16'd0);
        check("mid_empty", 16'(o_byte_rdy), 16'd1);
        check("mid_req_rdy", 16'(o_req_rdy), 16'd1);
        bq.push_back(8'h80);
        req(4'd0, cyc, m);
        check("mid_ff_clr", 16'(m), 16'd0);
        check("mid_err", 16'(o_err), 16'd0);

        // 0x50: two "01" tokens, then 00000 1 + eleven ones at k=11
        do_reset();
        bq.push_back(8'h50);
        wait_load();
        req(4'd0, cyc, m);
        check("w_tok1", 16'(m), 16'd1);
        req(4'd0, cyc, m);
        check("w_tok2", 16'(m), 16'd1);
        bq.push_back(8'h7F);
        bq.push_back(8'hF8);
        req(4'd11, cyc, m);
        check("w_trunc", 16'(m), 16'd511);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
